// File: rtl/stack_pkg.sv
// Shared constants and enums for the operand-stack sequencer.
package stack_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_DUP   = 3'd3,
        OP_SWAP  = 3'd4,
        OP_OVER  = 3'd5,
        OP_BINOP = 3'd6,
        OP_CLEAR = 3'd7
    } stack_op_e;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_SWAP2 = 1'b1
    } stack_state_e;

endpackage

// File: rtl/stack_ctrl.sv
// Operand-stack sequencer driving a 2-read/1-write register file.
// Define STACK_CTRL_GUARD_EN to squash illegal commands and report them on err.
module stack_ctrl #(
    parameter int DATA_W = stack_pkg::DATA_W,
    parameter int SEL_W  = stack_pkg::SEL_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] tos,
    output logic [DATA_W-1:0] nos,
    output logic [SEL_W:0]    depth,
    output logic              err,
    output logic [SEL_W-1:0]  re_sel_a,
    output logic [SEL_W-1:0]  re_sel_b,
    input  logic [DATA_W-1:0] re_data_a,
    input  logic [DATA_W-1:0] re_data_b,
    output logic [SEL_W-1:0]  wr_sel,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en
);
    import stack_pkg::*;

    localparam logic [SEL_W:0] SP_FULL = {1'b1, {SEL_W{1'b0}}};
    localparam logic [SEL_W:0] SP_ONE  = (SEL_W+1)'(1);
    localparam logic [SEL_W:0] SP_TWO  = (SEL_W+1)'(2);

    stack_state_e      state_q, state_d;
    logic [SEL_W:0]    sp_q, sp_d;
    logic [DATA_W-1:0] swap_tmp_q, swap_tmp_d;
    logic [SEL_W-1:0]  sp_lo;
    logic              wr_raw;
    logic              exec;
    stack_op_e         op;

`ifdef STACK_CTRL_GUARD_EN
    logic err_q, err_d;
    logic legal;
`endif

    assign sp_lo     = sp_q[SEL_W-1:0];
    assign op        = stack_op_e'(cmd_op);
    assign re_sel_a  = sp_lo - SEL_W'(1);
    assign re_sel_b  = sp_lo - SEL_W'(2);
    assign tos       = re_data_a;
    assign nos       = re_data_b;
    assign depth     = sp_q;
    assign cmd_ready = (state_q == ST_READY);
    // A write must never reach the register file while reset is held.
    assign wr_en     = wr_raw & reset_n;

`ifdef STACK_CTRL_GUARD_EN
    assign err = err_q;

    always_comb begin
        legal = 1'b1;
        case (op)
            OP_PUSH:           legal = (sp_q < SP_FULL);
            OP_POP:            legal = (sp_q != '0);
            OP_DUP:            legal = (sp_q != '0) && (sp_q < SP_FULL);
            OP_SWAP, OP_BINOP: legal = (sp_q >= SP_TWO);
            OP_OVER:           legal = (sp_q >= SP_TWO) && (sp_q < SP_FULL);
            default:           legal = 1'b1;
        endcase
    end
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        swap_tmp_d = swap_tmp_q;
        wr_raw     = 1'b0;
        wr_sel     = sp_lo - SEL_W'(1);
        wr_data    = cmd_data;
        exec       = 1'b1;
`ifdef STACK_CTRL_GUARD_EN
        err_d      = err_q;
        exec       = legal;
`endif
        case (state_q)
            ST_READY: begin
                if (cmd_valid) begin
`ifdef STACK_CTRL_GUARD_EN
                    if (!legal) err_d = 1'b1;
`endif
                    if (exec) begin
                        case (op)
                            OP_PUSH: begin
                                wr_raw  = 1'b1;
                                wr_sel  = sp_lo;
                                wr_data = cmd_data;
                                sp_d    = sp_q + SP_ONE;
                            end
                            OP_POP: sp_d = sp_q - SP_ONE;
                            OP_DUP: begin
                                wr_raw  = 1'b1;
                                wr_sel  = sp_lo;
                                wr_data = re_data_a;
                                sp_d    = sp_q + SP_ONE;
                            end
                            OP_SWAP: begin
                                wr_raw     = 1'b1;
                                wr_sel     = sp_lo - SEL_W'(1);
                                wr_data    = re_data_b;
                                swap_tmp_d = re_data_a;
                                state_d    = ST_SWAP2;
                            end
                            OP_OVER: begin
                                wr_raw  = 1'b1;
                                wr_sel  = sp_lo;
                                wr_data = re_data_b;
                                sp_d    = sp_q + SP_ONE;
                            end
                            OP_BINOP: begin
                                wr_raw  = 1'b1;
                                wr_sel  = sp_lo - SEL_W'(2);
                                wr_data = alu_result;
                                sp_d    = sp_q - SP_ONE;
                            end
                            OP_CLEAR: begin
                                sp_d = '0;
`ifdef STACK_CTRL_GUARD_EN
                                err_d = 1'b0;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_SWAP2: begin
                // Old TOS, held since the first cycle, lands in the NOS slot.
                wr_raw  = 1'b1;
                wr_sel  = sp_lo - SEL_W'(2);
                wr_data = swap_tmp_q;
                state_d = ST_READY;
            end
            default: state_d = ST_READY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_READY;
            sp_q       <= '0;
            swap_tmp_q <= '0;
`ifdef STACK_CTRL_GUARD_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            swap_tmp_q <= swap_tmp_d;
`ifdef STACK_CTRL_GUARD_EN
            err_q      <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural register file and adder ALU.
module tb_stack_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] alu_result;
    logic [7:0] tos, nos;
    logic [3:0] depth;
    logic       err;
    logic [2:0] re_sel_a, re_sel_b, wr_sel;
    logic [7:0] re_data_a, re_data_b, wr_data;
    logic       wr_en;

    logic [7:0] rf [0:7];

    int checks   = 0;
    int failures = 0;

    logic       cap_we;
    logic [2:0] cap_ws;
    logic [7:0] cap_wd;

    always #5 clock = ~clock;

    always_ff @(posedge clock) begin
        if (wr_en) rf[wr_sel] <= wr_data;
    end

    assign re_data_a  = rf[re_sel_a];
    assign re_data_b  = rf[re_sel_b];
    assign alu_result = re_data_a + re_data_b;

    stack_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .alu_result (alu_result),
        .tos        (tos),
        .nos        (nos),
        .depth      (depth),
        .err        (err),
        .re_sel_a   (re_sel_a),
        .re_sel_b   (re_sel_b),
        .re_data_a  (re_data_a),
        .re_data_b  (re_data_b),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .wr_en      (wr_en)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one command starting just after an edge; capture the write port before the accept edge.
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        #1;
        cap_we = wr_en;
        cap_ws = wr_sel;
        cap_wd = wr_data;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 8'h00;
        @(posedge clock);
        #1;
        chk("rst_wr_en_held", {15'd0, wr_en}, 16'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rst_ready", {15'd0, cmd_ready}, 16'd1);
        chk("rst_depth", {12'd0, depth}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_wr_en", {15'd0, wr_en}, 16'd0);
        chk("rst_wr_sel", {13'd0, wr_sel}, 16'd7);
        chk("rst_sel_a", {13'd0, re_sel_a}, 16'd7);
        chk("rst_sel_b", {13'd0, re_sel_b}, 16'd6);

        do_cmd(3'd1, 8'h11);
        chk("push0_sel", {12'd0, cap_we, cap_ws}, 16'h8);
        do_cmd(3'd1, 8'h22);
        chk("push1_sel", {12'd0, cap_we, cap_ws}, 16'h9);
        do_cmd(3'd1, 8'h33);
        chk("push2_sel", {12'd0, cap_we, cap_ws}, 16'hA);
        chk("push_depth", {12'd0, depth}, 16'd3);
        chk("push_tos", {8'd0, tos}, 16'h33);
        chk("push_nos", {8'd0, nos}, 16'h22);
        chk("push_rf0", {8'd0, rf[0]}, 16'h11);

        do_cmd(3'd2, 8'h00);
        chk("pop_depth", {12'd0, depth}, 16'd2);
        do_cmd(3'd4, 8'h00);
        chk("swap1_write", {4'd0, cap_we, cap_ws, cap_wd}, {4'd0, 1'b1, 3'd1, 8'h11});
        chk("swap2_ready", {15'd0, cmd_ready}, 16'd0);
        #1;
        chk("swap2_write", {4'd0, wr_en, wr_sel, wr_data}, {4'd0, 1'b1, 3'd0, 8'h22});
        // A command offered during the second swap cycle must be ignored.
        do_cmd(3'd1, 8'hEE);
        chk("swap_done_ready", {15'd0, cmd_ready}, 16'd1);
        chk("swap_tos", {8'd0, tos}, 16'h11);
        chk("swap_nos", {8'd0, nos}, 16'h22);
        chk("swap_depth", {12'd0, depth}, 16'd2);

        do_cmd(3'd7, 8'h00);
        do_cmd(3'd1, 8'h05);
        do_cmd(3'd1, 8'h03);
        do_cmd(3'd6, 8'h00);
        chk("binop_write", {4'd0, cap_we, cap_ws, cap_wd}, {4'd0, 1'b1, 3'd0, 8'h08});
        chk("binop_depth", {12'd0, depth}, 16'd1);
        chk("binop_tos", {8'd0, tos}, 16'h08);

        do_cmd(3'd3, 8'h00);
        chk("dup_depth", {12'd0, depth}, 16'd2);
        chk("dup_nos_tos", {tos, nos}, 16'h0808);
        do_cmd(3'd1, 8'h77);
        do_cmd(3'd5, 8'h00);
        chk("over_depth", {12'd0, depth}, 16'd4);
        chk("over_tos_nos", {tos, nos}, 16'h0877);

        do_cmd(3'd7, 8'h00);
        chk("clear_depth", {12'd0, depth}, 16'd0);
        for (int i = 0; i < 8; i++) do_cmd(3'd1, 8'hA0 + 8'(i));
        chk("full_depth", {12'd0, depth}, 16'd8);
        chk("full_tos_nos", {tos, nos}, 16'hA7A6);
        do_cmd(3'd1, 8'hFF);
`ifdef STACK_CTRL_GUARD_EN
        chk("ovf_no_write", {15'd0, cap_we}, 16'd0);
        chk("ovf_depth", {12'd0, depth}, 16'd8);
        chk("ovf_err", {15'd0, err}, 16'd1);
        chk("ovf_rf0", {8'd0, rf[0]}, 16'hA0);
        do_cmd(3'd7, 8'h00);
        chk("ovf_clear", {11'd0, err, depth}, 16'd0);
        do_cmd(3'd2, 8'h00);
        chk("udf_no_write", {15'd0, cap_we}, 16'd0);
        chk("udf_state", {11'd0, err, depth}, 16'h10);
        do_cmd(3'd7, 8'h00);
        chk("udf_clear", {11'd0, err, depth}, 16'd0);
`else
        chk("wrap_write", {12'd0, cap_we, cap_ws}, 16'h8);
        chk("wrap_depth", {12'd0, depth}, 16'd9);
        chk("wrap_err", {15'd0, err}, 16'd0);
        chk("wrap_rf0", {8'd0, rf[0]}, 16'hFF);
        do_cmd(3'd7, 8'h00);
        chk("wrap_clear", {12'd0, depth}, 16'd0);
`endif

        do_cmd(3'd1, 8'h01);
        do_cmd(3'd1, 8'h02);
        do_cmd(3'd4, 8'h00);
        reset_n = 1'b0;
        #1;
        chk("rst_swap2_wr_en", {15'd0, wr_en}, 16'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rst_swap2_depth", {12'd0, depth}, 16'd0);
        chk("rst_swap2_ready", {15'd0, cmd_ready}, 16'd1);
        chk("rst_swap2_rf0", {8'd0, rf[0]}, 16'h01);
        chk("rst_swap2_rf1", {8'd0, rf[1]}, 16'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
